// File: rtl/pixel_scanner.sv
// pixel_scanner: raster coordinate generator for a fixed-latency pixel source.
// Coordinates are issued in raster order; returning pixels are tagged through a
// latency pipeline and buffered in a small FIFO that feeds a valid/ready stream.
//
// Handshake: a beat moves on a rising clk edge where m_valid and m_ready are
// both high; m_valid never depends on m_ready, and while m_valid=1 with
// m_ready=0 the head beat (m_data/m_sof/m_eol) holds stable.
module pixel_scanner #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int SRC_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic [$clog2(H_ACTIVE)-1:0]   x_out,
    output logic [$clog2(V_ACTIVE)-1:0]   y_out,
    output logic                          coord_valid,
    input  logic [15:0]                   pixel_in,
    output logic [15:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          frame_done,
    output logic [1:0]                    state_dbg
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + SRC_LATENCY + 2);

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;

    // Per-request tags travelling alongside the source latency
    logic [SRC_LATENCY-1:0] v_pipe;
    logic [SRC_LATENCY-1:0] sof_pipe;
    logic [SRC_LATENCY-1:0] eol_pipe;
    logic [SRC_LATENCY-1:0] last_pipe;

    // FIFO storage: pixel plus {last, sof, eol} flags
    logic [15:0]   mem_data [FIFO_DEPTH];
    logic [2:0]    mem_flag [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] in_flight;

    logic issue;
    logic push;
    logic pop;
    logic at_x_last;
    logic at_y_last;
    logic req_sof;
    logic req_eol;
    logic req_last;

    // Count requests still inside the source latency window
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < SRC_LATENCY; i++) begin
            in_flight = in_flight + CW'(v_pipe[i]);
        end
    end

    assign at_x_last = (x_out == X_LAST);
    assign at_y_last = (y_out == Y_LAST);
    assign req_sof   = (x_out == '0) && (y_out == '0);
    assign req_eol   = at_x_last;
    assign req_last  = at_x_last && at_y_last;

    assign pop  = (occ != '0) && m_ready;
    assign push = v_pipe[SRC_LATENCY-1];

    // A pop on this edge frees a slot, so it is credited before the space
    // test; this keeps one pixel per cycle with FIFO_DEPTH = SRC_LATENCY+1
    // while occupancy plus in-flight still never exceeds FIFO_DEPTH.
    assign issue       = (state == SCAN) && ((occ + in_flight) < (DEPTH_C + CW'(pop)));
    assign coord_valid = issue;
    assign state_dbg   = state;

    // Scan FSM and raster coordinate counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            x_out <= '0;
            y_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= SCAN;
                end
                SCAN: begin
                    if (issue) begin
                        if (at_x_last) begin
                            x_out <= '0;
                            y_out <= at_y_last ? '0 : y_out + YW'(1);
                        end else begin
                            x_out <= x_out + XW'(1);
                        end
                        if (req_last && !enable) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((occ == '0) && (in_flight == '0)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Latency pipeline carrying valid and position tags for each request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_pipe    <= '0;
            sof_pipe  <= '0;
            eol_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            v_pipe[0]    <= issue;
            sof_pipe[0]  <= issue && req_sof;
            eol_pipe[0]  <= issue && req_eol;
            last_pipe[0] <= issue && req_last;
            for (int i = 1; i < SRC_LATENCY; i++) begin
                v_pipe[i]    <= v_pipe[i-1];
                sof_pipe[i]  <= sof_pipe[i-1];
                eol_pipe[i]  <= eol_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    // FIFO storage write; contents are qualified by occupancy so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= pixel_in;
            mem_flag[wr_ptr] <= {last_pipe[SRC_LATENCY-1], sof_pipe[SRC_LATENCY-1],
                                 eol_pipe[SRC_LATENCY-1]};
        end
    end

    // FIFO pointers, occupancy and end-of-frame pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            occ        <= occ + CW'(push) - CW'(pop);
            frame_done <= pop && mem_flag[rd_ptr][2];
        end
    end

    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? mem_data[rd_ptr] : 16'h0000;
    assign m_sof   = m_valid && mem_flag[rd_ptr][1];
    assign m_eol   = m_valid && mem_flag[rd_ptr][0];

endmodule

// File: doc/pixel_scanner.md
PIXEL_SCANNER -- requirements
Module: pixel_scanner

Interface
REQ-001 Parameter H_ACTIVE, default 320: pixels per line.
REQ-002 Parameter V_ACTIVE, default 240: lines per frame.
REQ-003 Parameter SRC_LATENCY, default 1: clock edges from a coordinate being sampled by the pixel source to its pixel appearing on pixel_in (range 1-4).
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer entries; SHALL be at least SRC_LATENCY+1.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 enable  input  1  level; high requests continuous frame scanning.
REQ-008 x_out  output  $clog2(H_ACTIVE)  column presented to the pixel source.
REQ-009 y_out  output  $clog2(V_ACTIVE)  row presented to the pixel source.
REQ-010 coord_valid  output  1  x_out/y_out are a real request this cycle.
REQ-011 pixel_in  input  16  RGB565 pixel from the source, returned SRC_LATENCY edges after its request.
REQ-012 m_data  output  16  pixel at the FIFO head.
REQ-013 m_valid  output  1  m_data/m_sof/m_eol are valid.
REQ-014 m_ready  input  1  downstream accepts; a beat transfers on a rising edge with m_valid and m_ready both high.
REQ-015 m_sof  output  1  head pixel is (0,0).
REQ-016 m_eol  output  1  head pixel has x = H_ACTIVE-1.
REQ-017 frame_done  output  1  one-cycle pulse after the last pixel of a frame transfers.

Function
REQ-018 The FSM SHALL have three states: IDLE, SCAN and DRAIN.
REQ-019 IDLE->SCAN SHALL occur on an edge sampling enable=1, with the coordinate at (0,0).
REQ-020 SCAN->DRAIN SHALL occur when the request for (H_ACTIVE-1, V_ACTIVE-1) issues while enable=0.
REQ-021 If enable=1 at that issue, the FSM SHALL stay in SCAN and continue seamlessly with (0,0) of the next frame.
REQ-022 DRAIN->IDLE SHALL occur when the FIFO is empty and no requests are in flight.
REQ-023 enable falling mid-frame SHALL NOT truncate the frame; enable is ignored in DRAIN.
REQ-024 A request issues (coord_valid=1) only in SCAN and only when FIFO occupancy plus in-flight requests is less than FIFO_DEPTH; otherwise coord_valid=0 and x_out/y_out hold.
REQ-025 Each issued request SHALL advance x; at x=H_ACTIVE-1, x wraps to 0 and y increments; at y=V_ACTIVE-1, y wraps to 0.
REQ-026 A SRC_LATENCY-deep shift register SHALL carry valid/sof/eol per request; pixel_in is written to the FIFO only on edges where the delayed valid is 1, and other pixel_in samples are discarded.
REQ-027 m_valid SHALL equal FIFO non-empty, with data visible the cycle after the write edge.
REQ-028 Minimum latency from a coordinate's first cycle to its m_valid SHALL be SRC_LATENCY+1 cycles.
REQ-029 Sustained throughput with m_ready=1 SHALL be one pixel per cycle, with no bubbles across line or frame wrap.
REQ-030 A simultaneous FIFO push and pop SHALL leave occupancy unchanged, including when the FIFO is full or empty.
REQ-031 m_data/m_sof/m_eol SHALL hold stable while m_valid=1 and m_ready=0.
REQ-032 The FIFO SHALL never overflow, and no pixel is ever dropped or duplicated.
REQ-033 frame_done SHALL pulse for exactly one cycle after a beat with x=H_ACTIVE-1, y=V_ACTIVE-1 transfers.

Reset
REQ-034 While rst=0, the block SHALL hold: state IDLE, x_out=0, y_out=0, coord_valid=0, m_valid=0, m_sof=0, m_eol=0, frame_done=0, m_data=0, FIFO empty, latency pipeline cleared.
REQ-035 Reset asserted mid-frame SHALL discard all buffered and in-flight pixels.
REQ-036 After reset releases, the next scan SHALL begin at (0,0) with m_sof=1.

Verification
REQ-037 Source models pixel=(x+y) replicated into RGB565, enable=1, m_ready=1 -> first m_valid SRC_LATENCY+1 cycles after first coord_valid, m_sof=1 on beat 0, 76800 consecutive beats, m_eol every 320th beat, frame_done once, next frame's m_sof in the following beat.
REQ-038 m_ready=0 from start -> exactly FIFO_DEPTH requests issue, then coord_valid=0, m_valid=1 and m_data frozen at the (0,0) pixel; m_ready=1 -> all 4 pixels drain in order with no loss.
REQ-039 Random 50% m_ready over 2 frames -> output sequence matches the raster-order model exactly; no overflow; m_sof/m_eol correctly placed.
REQ-040 enable=0 while request (100,50) issues -> frame completes to (319,239), frame_done pulses, FSM returns to IDLE, coord_valid stays 0.
REQ-041 rst=0 asserted at (200,120) with FIFO holding 3 entries -> all outputs 0 immediately; after release with enable=1 -> first beat is (0,0) with m_sof=1.
REQ-042 SRC_LATENCY=3, FIFO_DEPTH=4 -> same results as REQ-037/038; in-flight plus occupancy never exceeds 4.
